// File: rtl/drac_pkg.sv
// Shared CSR port types: command encodings, arbiter state and the
// registered request that drives the regfile port.
package drac_pkg;

   localparam int CSR_ADDR_W = 12;
   localparam int CSR_DATA_W = 64;
   localparam int CSR_CMD_W  = 3;

   typedef enum logic [CSR_CMD_W-1:0] {
      CSR_CMD_NOPE  = 3'b000,
      CSR_CMD_WRITE = 3'b001,
      CSR_CMD_SET   = 3'b010,
      CSR_CMD_CLEAR = 3'b011,
      CSR_CMD_READ  = 3'b101
   } csr_cmd_t;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_ISSUE,
      ARB_RESP
   } arb_state_t;

   typedef struct packed {
      logic [CSR_CMD_W-1:0]  cmd;
      logic [CSR_ADDR_W-1:0] addr;
      logic [CSR_DATA_W-1:0] wdata;
   } csr_port_req_t;

   // The debug ring only knows read/write; map onto regfile commands.
   function automatic logic [CSR_CMD_W-1:0] dbg_cmd(input logic we);
      return we ? CSR_CMD_WRITE : CSR_CMD_READ;
   endfunction

endpackage

// File: rtl/csr_port_arbiter.sv
// Shares the csr_regfile port between the core pipeline and the debug ring:
// accept -> one-cycle issue -> response held until consumed.
module csr_port_arbiter
   import drac_pkg::*;
#(
   parameter int AddrWidth  = 12,
   parameter int DataWidth  = 64,
   parameter int CmdWidth   = 3,
   parameter int MaxDbgWait = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 core_req_valid_i,
   output logic                 core_req_ready_o,
   input  logic [CmdWidth-1:0]  core_cmd_i,
   input  logic [AddrWidth-1:0] core_addr_i,
   input  logic [DataWidth-1:0] core_wdata_i,
   input  logic                 dbg_req_valid_i,
   output logic                 dbg_req_ready_o,
   input  logic                 dbg_we_i,
   input  logic [AddrWidth-1:0] dbg_addr_i,
   input  logic [DataWidth-1:0] dbg_wdata_i,
   output logic                 rsp_valid_o,
   input  logic                 rsp_ready_i,
   output logic                 rsp_dbg_o,
   output logic [DataWidth-1:0] rsp_rdata_o,
   output logic                 rsp_xcpt_o,
   output logic [CmdWidth-1:0]  csr_op_o,
   output logic [AddrWidth-1:0] csr_addr_o,
   output logic [DataWidth-1:0] csr_wdata_o,
   input  logic [DataWidth-1:0] csr_rdata_i,
   input  logic                 csr_xcpt_i,
   input  logic                 halt_i,
   input  logic                 flush_i
);

   localparam logic [7:0] WaitMax = 8'(MaxDbgWait);

   arb_state_t     state_q;
   csr_port_req_t  port_q;
   logic           owner_q;
   logic [7:0]     wait_q;
   logic           rsp_valid_q;
   logic [DataWidth-1:0] rdata_q;
   logic           xcpt_q;

   logic idle_ok, dbg_win, core_win, core_drop;

   // Ready is gated by reset so every output reads 0 while rst_ni is low.
   always_comb begin
      idle_ok   = rst_ni && (state_q == ARB_IDLE) && !halt_i;
      dbg_win   = idle_ok && dbg_req_valid_i && (!core_req_valid_i || wait_q == WaitMax);
      core_win  = idle_ok && !dbg_win && core_req_valid_i && !flush_i;
      core_drop = !owner_q && flush_i;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= ARB_IDLE;
         port_q      <= '{cmd: CSR_CMD_NOPE, addr: '0, wdata: '0};
         owner_q     <= 1'b0;
         wait_q      <= '0;
         rsp_valid_q <= 1'b0;
         rdata_q     <= '0;
         xcpt_q      <= 1'b0;
      end else begin
         // Counts arbitration cycles in which a pending debug request lost.
         if (!dbg_req_valid_i || dbg_win)
            wait_q <= '0;
         else if (state_q == ARB_IDLE && wait_q != WaitMax)
            wait_q <= wait_q + 8'd1;

         case (state_q)
            ARB_IDLE: begin
               if (dbg_win) begin
                  port_q  <= '{cmd: dbg_cmd(dbg_we_i), addr: dbg_addr_i, wdata: dbg_wdata_i};
                  owner_q <= 1'b1;
                  state_q <= ARB_ISSUE;
               end else if (core_win) begin
                  port_q  <= '{cmd: core_cmd_i, addr: core_addr_i, wdata: core_wdata_i};
                  owner_q <= 1'b0;
                  state_q <= ARB_ISSUE;
               end
            end
            ARB_ISSUE: begin
               port_q  <= '{cmd: CSR_CMD_NOPE, addr: '0, wdata: '0};
               rdata_q <= csr_rdata_i;
               xcpt_q  <= csr_xcpt_i;
               // A flushed core access still hits the regfile; only its response is dropped.
               if (core_drop) begin
                  state_q <= ARB_IDLE;
               end else begin
                  state_q     <= ARB_RESP;
                  rsp_valid_q <= 1'b1;
               end
            end
            ARB_RESP: begin
               if (rsp_ready_i || core_drop) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= ARB_IDLE;
               end
            end
            default: state_q <= ARB_IDLE;
         endcase
      end
   end

   assign core_req_ready_o = core_win;
   assign dbg_req_ready_o  = dbg_win;
   assign csr_op_o         = port_q.cmd;
   assign csr_addr_o       = port_q.addr;
   assign csr_wdata_o      = port_q.wdata;
   assign rsp_valid_o      = rsp_valid_q;
   assign rsp_dbg_o        = owner_q;
   assign rsp_rdata_o      = rdata_q;
   assign rsp_xcpt_o       = xcpt_q;

endmodule

// File: tb/tb_csr_port_arbiter.sv
// Directed scenarios plus a randomized run against a transaction-level model
// of the CSR port arbiter.
module tb_csr_port_arbiter;
   import drac_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        core_req_valid_i, core_req_ready_o;
   logic [2:0]  core_cmd_i;
   logic [11:0] core_addr_i;
   logic [63:0] core_wdata_i;
   logic        dbg_req_valid_i, dbg_req_ready_o, dbg_we_i;
   logic [11:0] dbg_addr_i;
   logic [63:0] dbg_wdata_i;
   logic        rsp_valid_o, rsp_ready_i, rsp_dbg_o, rsp_xcpt_o;
   logic [63:0] rsp_rdata_o;
   logic [2:0]  csr_op_o;
   logic [11:0] csr_addr_o;
   logic [63:0] csr_wdata_o, csr_rdata_i;
   logic        csr_xcpt_i, halt_i, flush_i;

   int checks = 0;
   int errors = 0;

   csr_port_arbiter #(.AddrWidth(12), .DataWidth(64), .CmdWidth(3), .MaxDbgWait(8)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .core_req_valid_i(core_req_valid_i), .core_req_ready_o(core_req_ready_o),
      .core_cmd_i(core_cmd_i), .core_addr_i(core_addr_i), .core_wdata_i(core_wdata_i),
      .dbg_req_valid_i(dbg_req_valid_i), .dbg_req_ready_o(dbg_req_ready_o),
      .dbg_we_i(dbg_we_i), .dbg_addr_i(dbg_addr_i), .dbg_wdata_i(dbg_wdata_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_dbg_o(rsp_dbg_o),
      .rsp_rdata_o(rsp_rdata_o), .rsp_xcpt_o(rsp_xcpt_o),
      .csr_op_o(csr_op_o), .csr_addr_o(csr_addr_o), .csr_wdata_o(csr_wdata_o),
      .csr_rdata_i(csr_rdata_i), .csr_xcpt_i(csr_xcpt_i),
      .halt_i(halt_i), .flush_i(flush_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle_inputs();
      core_req_valid_i = 0; core_cmd_i = 0; core_addr_i = 0; core_wdata_i = 0;
      dbg_req_valid_i = 0; dbg_we_i = 0; dbg_addr_i = 0; dbg_wdata_i = 0;
      rsp_ready_i = 0; csr_rdata_i = 0; csr_xcpt_i = 0; halt_i = 0; flush_i = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_ni = 0;
      tick();
      tick();
      rst_ni = 1;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_ni = 0;
      core_req_valid_i = 1; dbg_req_valid_i = 1; csr_rdata_i = 64'hFFFF;
      #2;
      checks++; if (core_req_ready_o !== 0 || dbg_req_ready_o !== 0) begin errors++;
         $display("FAIL reset_ready: core=%b dbg=%b exp 0/0", core_req_ready_o, dbg_req_ready_o); end
      checks++; if (csr_op_o !== CSR_CMD_NOPE || csr_addr_o !== 0 || csr_wdata_o !== 0) begin errors++;
         $display("FAIL reset_port: op=%0d addr=%h wdata=%h exp 0", csr_op_o, csr_addr_o, csr_wdata_o); end
      checks++; if (rsp_valid_o !== 0 || rsp_dbg_o !== 0 || rsp_rdata_o !== 0 || rsp_xcpt_o !== 0) begin errors++;
         $display("FAIL reset_rsp: v=%b dbg=%b rdata=%h xcpt=%b exp 0", rsp_valid_o, rsp_dbg_o, rsp_rdata_o, rsp_xcpt_o); end
      tick();
      do_reset();
   endtask

   task automatic test_core_read();
      do_reset();
      core_req_valid_i = 1; core_cmd_i = CSR_CMD_READ; core_addr_i = 12'hF14; csr_rdata_i = 64'h3;
      #2;
      checks++; if (core_req_ready_o !== 1 || dbg_req_ready_o !== 0) begin errors++;
         $display("FAIL core_read_accept: core=%b dbg=%b exp 1/0", core_req_ready_o, dbg_req_ready_o); end
      tick(); core_req_valid_i = 0; #2;
      checks++; if (csr_op_o !== CSR_CMD_READ || csr_addr_o !== 12'hF14) begin errors++;
         $display("FAIL core_read_issue: op=%0d addr=%h exp 5/f14", csr_op_o, csr_addr_o); end
      tick(); csr_rdata_i = 64'h99; #2;
      checks++; if (rsp_valid_o !== 1 || rsp_dbg_o !== 0 || rsp_rdata_o !== 64'h3) begin errors++;
         $display("FAIL core_read_rsp: v=%b dbg=%b rdata=%h exp 1/0/3", rsp_valid_o, rsp_dbg_o, rsp_rdata_o); end
      rsp_ready_i = 1;
      tick(); rsp_ready_i = 0; #2;
      checks++; if (rsp_valid_o !== 0 || csr_op_o !== CSR_CMD_NOPE) begin errors++;
         $display("FAIL core_read_done: v=%b op=%0d exp 0/0", rsp_valid_o, csr_op_o); end
   endtask

   task automatic test_dbg_starvation();
      int  ng = 0;
      bit  owners[10];
      do_reset();
      core_req_valid_i = 1; core_cmd_i = CSR_CMD_READ; core_addr_i = 12'h001;
      dbg_req_valid_i = 1; dbg_we_i = 0; dbg_addr_i = 12'h002; rsp_ready_i = 1;
      for (int c = 0; c < 80 && ng < 10; c++) begin
         csr_rdata_i = {$urandom, $urandom};
         #2;
         if (rsp_valid_o && ng > 0) begin
            checks++; if (rsp_dbg_o !== owners[ng-1]) begin errors++;
               $display("FAIL starve_rsp_owner: grant %0d dbg=%b exp %b", ng, rsp_dbg_o, owners[ng-1]); end
         end
         if (dbg_req_ready_o || core_req_ready_o) begin
            owners[ng] = dbg_req_ready_o;
            ng++;
         end
         tick();
      end
      checks++; if (ng != 10) begin errors++;
         $display("FAIL starve_grants: got %0d grants exp 10 within budget", ng); end
      else begin
         for (int g = 0; g < 8; g++) begin
            checks++; if (owners[g] !== 1'b0) begin errors++;
               $display("FAIL starve_core_grant%0d: dbg=%b exp 0", g, owners[g]); end
         end
         checks++; if (owners[8] !== 1'b1) begin errors++;
            $display("FAIL starve_dbg_grant: dbg=%b exp 1", owners[8]); end
         checks++; if (owners[9] !== 1'b0) begin errors++;
            $display("FAIL starve_after_dbg: dbg=%b exp 0", owners[9]); end
      end
      idle_inputs(); rsp_ready_i = 1;
      tick(); tick(); tick();
   endtask

   task automatic test_halt();
      do_reset();
      halt_i = 1; core_req_valid_i = 1; core_cmd_i = CSR_CMD_READ; core_addr_i = 12'h010;
      dbg_req_valid_i = 1; dbg_addr_i = 12'h020;
      for (int c = 0; c < 5; c++) begin
         #2;
         checks++; if (core_req_ready_o !== 0 || dbg_req_ready_o !== 0 || csr_op_o !== CSR_CMD_NOPE) begin errors++;
            $display("FAIL halt_block c%0d: core=%b dbg=%b op=%0d exp 0/0/0", c, core_req_ready_o, dbg_req_ready_o, csr_op_o); end
         tick();
      end
      halt_i = 0; #2;
      checks++; if (core_req_ready_o !== 1 || dbg_req_ready_o !== 0) begin errors++;
         $display("FAIL halt_release: core=%b dbg=%b exp 1/0", core_req_ready_o, dbg_req_ready_o); end
      tick(); idle_inputs(); rsp_ready_i = 1;
      tick(); tick(); tick();
   endtask

   task automatic test_flush_issue();
      do_reset();
      core_req_valid_i = 1; core_cmd_i = CSR_CMD_WRITE; core_addr_i = 12'h300; core_wdata_i = 64'h1234_5678_9ABC_DEF0;
      #2;
      checks++; if (core_req_ready_o !== 1) begin errors++;
         $display("FAIL flush_accept: core=%b exp 1", core_req_ready_o); end
      tick(); core_req_valid_i = 0; flush_i = 1; #2;
      checks++; if (csr_op_o !== CSR_CMD_WRITE || csr_addr_o !== 12'h300 || csr_wdata_o !== 64'h1234_5678_9ABC_DEF0) begin errors++;
         $display("FAIL flush_issue: op=%0d addr=%h wdata=%h exp 1/300/123456789abcdef0", csr_op_o, csr_addr_o, csr_wdata_o); end
      tick(); flush_i = 0; core_req_valid_i = 1; core_cmd_i = CSR_CMD_READ; #2;
      checks++; if (csr_op_o !== CSR_CMD_NOPE || rsp_valid_o !== 0) begin errors++;
         $display("FAIL flush_drop: op=%0d rsp_v=%b exp 0/0", csr_op_o, rsp_valid_o); end
      checks++; if (core_req_ready_o !== 1) begin errors++;
         $display("FAIL flush_idle: core_ready=%b exp 1", core_req_ready_o); end
      tick(); core_req_valid_i = 0; rsp_ready_i = 1;
      tick(); tick();
      idle_inputs();
   endtask

   task automatic test_rsp_hold();
      do_reset();
      dbg_req_valid_i = 1; dbg_we_i = 0; dbg_addr_i = 12'h7B0; #2;
      checks++; if (dbg_req_ready_o !== 1) begin errors++;
         $display("FAIL hold_accept: dbg=%b exp 1", dbg_req_ready_o); end
      tick(); dbg_req_valid_i = 0; csr_rdata_i = 64'hDEAD; #2;
      checks++; if (csr_op_o !== CSR_CMD_READ || csr_addr_o !== 12'h7B0) begin errors++;
         $display("FAIL hold_issue: op=%0d addr=%h exp 5/7b0", csr_op_o, csr_addr_o); end
      tick(); core_req_valid_i = 1; core_cmd_i = CSR_CMD_READ; core_addr_i = 12'h111;
      for (int c = 0; c < 5; c++) begin
         csr_rdata_i = {$urandom, $urandom};
         rsp_ready_i = (c == 4);
         #2;
         checks++; if (rsp_valid_o !== 1 || rsp_dbg_o !== 1 || rsp_rdata_o !== 64'hDEAD) begin errors++;
            $display("FAIL hold_stable c%0d: v=%b dbg=%b rdata=%h exp 1/1/dead", c, rsp_valid_o, rsp_dbg_o, rsp_rdata_o); end
         checks++; if (core_req_ready_o !== 0) begin errors++;
            $display("FAIL hold_no_accept c%0d: core=%b exp 0", c, core_req_ready_o); end
         tick();
      end
      rsp_ready_i = 0; #2;
      checks++; if (rsp_valid_o !== 0 || core_req_ready_o !== 1) begin errors++;
         $display("FAIL hold_after: v=%b core=%b exp 0/1", rsp_valid_o, core_req_ready_o); end
      tick(); idle_inputs(); rsp_ready_i = 1;
      tick(); tick();
   endtask

   task automatic test_reset_mid();
      do_reset();
      core_req_valid_i = 1; core_cmd_i = CSR_CMD_READ; core_addr_i = 12'h342; csr_rdata_i = 64'h55;
      tick(); core_req_valid_i = 0;
      tick(); #2;
      checks++; if (rsp_valid_o !== 1 || rsp_rdata_o !== 64'h55) begin errors++;
         $display("FAIL mid_pre: v=%b rdata=%h exp 1/55", rsp_valid_o, rsp_rdata_o); end
      core_req_valid_i = 1;
      #1 rst_ni = 0;
      #1;
      checks++; if (rsp_valid_o !== 0 || rsp_rdata_o !== 0 || csr_op_o !== CSR_CMD_NOPE || core_req_ready_o !== 0) begin errors++;
         $display("FAIL mid_async: v=%b rdata=%h op=%0d core=%b exp 0", rsp_valid_o, rsp_rdata_o, csr_op_o, core_req_ready_o); end
      tick(); rst_ni = 1;
      core_addr_i = 12'hF14; csr_rdata_i = 64'h3; #2;
      checks++; if (core_req_ready_o !== 1) begin errors++;
         $display("FAIL mid_fresh_accept: core=%b exp 1", core_req_ready_o); end
      tick(); core_req_valid_i = 0; #2;
      checks++; if (csr_op_o !== CSR_CMD_READ || csr_addr_o !== 12'hF14) begin errors++;
         $display("FAIL mid_fresh_issue: op=%0d addr=%h exp 5/f14", csr_op_o, csr_addr_o); end
      tick(); #2;
      checks++; if (rsp_valid_o !== 1 || rsp_rdata_o !== 64'h3 || rsp_dbg_o !== 0) begin errors++;
         $display("FAIL mid_fresh_rsp: v=%b rdata=%h dbg=%b exp 1/3/0", rsp_valid_o, rsp_rdata_o, rsp_dbg_o); end
      rsp_ready_i = 1;
      tick(); idle_inputs();
   endtask

   // Transaction model: one access in flight, tracked by its age since acceptance.
   task automatic test_random();
      logic [2:0] cmds [4] = '{3'd1, 3'd2, 3'd3, 3'd5};
      int          age = 0, wcnt = 0;
      bit          a_dbg = 0, c_xcpt = 0;
      logic [2:0]  a_cmd = 0;
      logic [11:0] a_addr = 0;
      logic [63:0] a_wdata = 0, c_rdata = 0;
      bit          e_drdy, e_crdy;
      do_reset();
      for (int c = 0; c < 600; c++) begin
         core_req_valid_i = ($urandom_range(0, 9) < 7);
         core_cmd_i = cmds[$urandom_range(0, 3)];
         core_addr_i = 12'($urandom); core_wdata_i = {$urandom, $urandom};
         dbg_req_valid_i = ($urandom_range(0, 9) < 4);
         dbg_we_i = 1'($urandom); dbg_addr_i = 12'($urandom); dbg_wdata_i = {$urandom, $urandom};
         halt_i = ($urandom_range(0, 9) == 0);
         flush_i = ($urandom_range(0, 9) == 0);
         rsp_ready_i = ($urandom_range(0, 9) < 6);
         csr_rdata_i = {$urandom, $urandom}; csr_xcpt_i = 1'($urandom);
         #2;
         e_drdy = (age == 0) && !halt_i && dbg_req_valid_i && (!core_req_valid_i || wcnt == 8);
         e_crdy = (age == 0) && !halt_i && !e_drdy && core_req_valid_i && !flush_i;
         checks++; if (dbg_req_ready_o !== e_drdy || core_req_ready_o !== e_crdy) begin errors++;
            $display("FAIL rand_ready c%0d: dbg=%b core=%b exp %b/%b", c, dbg_req_ready_o, core_req_ready_o, e_drdy, e_crdy); end
         checks++;
         if (csr_op_o !== (age == 1 ? a_cmd : 3'd0) || csr_addr_o !== (age == 1 ? a_addr : 12'd0) ||
             csr_wdata_o !== (age == 1 ? a_wdata : 64'd0)) begin errors++;
            $display("FAIL rand_port c%0d: op=%0d addr=%h wdata=%h exp op=%0d addr=%h", c, csr_op_o, csr_addr_o,
                     csr_wdata_o, (age == 1 ? a_cmd : 3'd0), (age == 1 ? a_addr : 12'd0)); end
         checks++; if (rsp_valid_o !== (age >= 2)) begin errors++;
            $display("FAIL rand_rsp_valid c%0d: v=%b exp %b", c, rsp_valid_o, (age >= 2)); end
         if (age >= 2) begin
            checks++; if (rsp_dbg_o !== a_dbg || rsp_rdata_o !== c_rdata || rsp_xcpt_o !== c_xcpt) begin errors++;
               $display("FAIL rand_rsp c%0d: dbg=%b rdata=%h xcpt=%b exp %b/%h/%b", c, rsp_dbg_o, rsp_rdata_o,
                        rsp_xcpt_o, a_dbg, c_rdata, c_xcpt); end
         end
         if (!dbg_req_valid_i || e_drdy) wcnt = 0;
         else if (age == 0 && wcnt < 8) wcnt++;
         if (e_drdy) begin
            a_dbg = 1; a_cmd = dbg_we_i ? 3'd1 : 3'd5; a_addr = dbg_addr_i; a_wdata = dbg_wdata_i; age = 1;
         end else if (e_crdy) begin
            a_dbg = 0; a_cmd = core_cmd_i; a_addr = core_addr_i; a_wdata = core_wdata_i; age = 1;
         end else if (age == 1) begin
            c_rdata = csr_rdata_i; c_xcpt = csr_xcpt_i;
            age = (!a_dbg && flush_i) ? 0 : 2;
         end else if (age >= 2) begin
            age = (rsp_ready_i || (!a_dbg && flush_i)) ? 0 : age + 1;
         end
         tick();
      end
      idle_inputs();
   endtask

   initial begin
      rst_ni = 0;
      idle_inputs();
      #1;
      test_reset();
      test_core_read();
      test_dbg_starvation();
      test_halt();
      test_flush_issue();
      test_rsp_hold();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
